// File: rtl/milano_pkg.sv
// milano_pkg: shared types and constants for the milano fetch unit.
//   fetch_state_e : fetch FSM states (IDLE, RUN, DRAIN)
//   INSTR_W       : instruction word width
//   PC_INC        : byte increment between sequential fetches
package milano_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } fetch_state_e;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned PC_INC  = 4;

endpackage

// File: rtl/milano_fetch_fifo.sv
// milano_fetch_fifo: DEPTH-entry synchronous FIFO with flush.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   flush_i       : empties the FIFO (overrides push/pop)
//   push_i/wdata_i: write one entry
//   pop_i         : drop the head entry
//   rdata_o       : head entry (valid when !empty_o)
//   cnt_o         : occupancy, full_o/empty_o status
module milano_fetch_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic [$clog2(DEPTH):0]   cnt_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    mem_d  = mem_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (flush_i) begin
      wptr_d = '0;
      rptr_d = '0;
      cnt_d  = '0;
    end else begin
      if (push_i) begin
        mem_d[wptr_q] = wdata_i;
        wptr_d        = wptr_q + PTR_W'(1);
      end
      if (pop_i) begin
        rptr_d = rptr_q + PTR_W'(1);
      end
      cnt_d = cnt_q + CNT_W'(push_i) - CNT_W'(pop_i);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q  <= '{default: '0};
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      mem_q  <= mem_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  assign rdata_o = mem_q[rptr_q];
  assign cnt_o   = cnt_q;
  assign full_o  = (cnt_q == CNT_W'(DEPTH));
  assign empty_o = (cnt_q == '0);

  // The parent's credit check must keep pushes away from a full FIFO.
  no_overflow_a : assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(push_i && full_o && !flush_i));

endmodule

// File: rtl/milano_fetch_unit.sv
// milano_fetch_unit: prefetching instruction-fetch unit between the
// instruction SRAM (req/gnt/rvalid, in-order) and the ID stage (valid/ready).
//   clk_i, rst_ni                 : clock, asynchronous active-low reset
//   boot_addr_i, fetch_enable_i   : first fetch address, fetch run/stop
//   branch_i, branch_addr_i       : one-cycle redirect with flush
//   instr_req_o/addr_o/gnt_i      : SRAM request channel
//   instr_rvalid_i/rdata_i        : SRAM response channel
//   id_valid_o/ready_i/instr_o/pc_o : ID handshake
//   busy_o                        : FSM active or fetches outstanding
// Optional feature: define MILANO_FETCH_BYPASS_EN to forward a response
// straight to ID when the FIFO is empty and nothing is being discarded.
module milano_fetch_unit
  import milano_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DEPTH  = 4
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [ADDR_W-1:0]  boot_addr_i,
  input  logic               fetch_enable_i,
  input  logic               branch_i,
  input  logic [ADDR_W-1:0]  branch_addr_i,
  output logic               instr_req_o,
  output logic [ADDR_W-1:0]  instr_addr_o,
  input  logic               instr_gnt_i,
  input  logic               instr_rvalid_i,
  input  logic [INSTR_W-1:0] instr_rdata_i,
  output logic               id_valid_o,
  input  logic               id_ready_i,
  output logic [INSTR_W-1:0] id_instr_o,
  output logic [ADDR_W-1:0]  id_pc_o,
  output logic               busy_o
);

  localparam int unsigned PTR_W   = $clog2(DEPTH);
  localparam int unsigned CNT_W   = PTR_W + 1;
  localparam int unsigned ENTRY_W = INSTR_W + ADDR_W;

  fetch_state_e      state_q, state_d;
  logic              boot_pend_q, boot_pend_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [CNT_W-1:0]  outstanding_q, outstanding_d;
  logic [CNT_W-1:0]  discard_q, discard_d;
  logic [ADDR_W-1:0] pcq_mem_q [DEPTH];
  logic [ADDR_W-1:0] pcq_mem_d [DEPTH];
  logic [PTR_W-1:0]  pcq_wptr_q, pcq_wptr_d, pcq_rptr_q, pcq_rptr_d;

  logic               fifo_push, fifo_pop, fifo_flush, fifo_full, fifo_empty;
  logic [ENTRY_W-1:0] fifo_wdata, fifo_rdata;
  logic [CNT_W-1:0]   fifo_cnt;

  logic               redirect, credit_ok, accepted, keep_beat;
  logic [ADDR_W-1:0]  resp_pc;

  assign redirect  = branch_i && (state_q != IDLE);
  assign credit_ok = !fifo_full &&
                     (({1'b0, fifo_cnt} + {1'b0, outstanding_q}) < (CNT_W+1)'(DEPTH));
  assign instr_req_o  = (state_q == RUN) && fetch_enable_i && !branch_i && credit_ok;
  assign instr_addr_o = pc_q;
  assign accepted     = instr_req_o && instr_gnt_i;
  // A beat arriving with a redirect belongs to the old stream and is dropped.
  assign keep_beat    = instr_rvalid_i && (discard_q == '0) && !redirect;
  assign resp_pc      = pcq_mem_q[pcq_rptr_q];
  assign fifo_wdata   = {instr_rdata_i, resp_pc};
  assign fifo_flush   = redirect;
  assign fifo_pop     = !fifo_empty && id_ready_i && !redirect;
  assign busy_o       = (state_q != IDLE) || (outstanding_q != '0);

`ifdef MILANO_FETCH_BYPASS_EN
  logic bypass;
  assign bypass     = keep_beat && fifo_empty;
  assign id_valid_o = !fifo_empty || bypass;
  assign fifo_push  = keep_beat && !(bypass && id_ready_i);
  assign {id_instr_o, id_pc_o} = !fifo_empty ? fifo_rdata :
                                 (bypass ? fifo_wdata : '0);
`else
  assign id_valid_o = !fifo_empty;
  assign fifo_push  = keep_beat;
  assign {id_instr_o, id_pc_o} = fifo_empty ? '0 : fifo_rdata;
`endif

  milano_fetch_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (fifo_flush),
    .push_i  (fifo_push),
    .wdata_i (fifo_wdata),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .cnt_o   (fifo_cnt),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_comb begin
    state_d       = state_q;
    boot_pend_d   = boot_pend_q;
    pc_d          = pc_q;
    discard_d     = discard_q;
    pcq_mem_d     = pcq_mem_q;
    pcq_wptr_d    = pcq_wptr_q;
    pcq_rptr_d    = pcq_rptr_q;
    outstanding_d = outstanding_q + CNT_W'(accepted) - CNT_W'(instr_rvalid_i);

    // The PC queue is never flushed: it still pairs every outstanding
    // response (kept or discarded) with its request address.
    if (accepted) begin
      pcq_mem_d[pcq_wptr_q] = pc_q;
      pcq_wptr_d            = pcq_wptr_q + PTR_W'(1);
      pc_d                  = pc_q + ADDR_W'(PC_INC);
    end
    if (instr_rvalid_i) begin
      pcq_rptr_d = pcq_rptr_q + PTR_W'(1);
    end

    if (redirect) begin
      // Everything still in flight after this edge is stale.
      discard_d = outstanding_d;
    end else if (instr_rvalid_i && (discard_q != '0)) begin
      discard_d = discard_q - CNT_W'(1);
    end

    unique case (state_q)
      IDLE: begin
        if (branch_i) begin
          pc_d        = branch_addr_i;
          boot_pend_d = 1'b0;
        end else if (boot_pend_q) begin
          pc_d = boot_addr_i;
        end
        if (fetch_enable_i) begin
          state_d     = RUN;
          boot_pend_d = 1'b0;
        end
      end
      RUN: begin
        if (!fetch_enable_i) begin
          state_d = (outstanding_d != '0) ? DRAIN : IDLE;
        end
      end
      DRAIN: begin
        if (outstanding_d == '0) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (redirect) begin
      pc_d = branch_addr_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= IDLE;
      boot_pend_q   <= 1'b1;
      pc_q          <= '0;
      outstanding_q <= '0;
      discard_q     <= '0;
      pcq_mem_q     <= '{default: '0};
      pcq_wptr_q    <= '0;
      pcq_rptr_q    <= '0;
    end else begin
      state_q       <= state_d;
      boot_pend_q   <= boot_pend_d;
      pc_q          <= pc_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
      pcq_mem_q     <= pcq_mem_d;
      pcq_wptr_q    <= pcq_wptr_d;
      pcq_rptr_q    <= pcq_rptr_d;
    end
  end

endmodule

// File: tb/tb_milano_fetch_unit.sv
// Testbench for milano_fetch_unit (ADDR_W=32, DEPTH=4) with a 1-cycle
// in-order SRAM model whose response data is addr ^ RD_XOR.
module tb_milano_fetch_unit;

  localparam logic [31:0] RD_XOR = 32'h5A5A_0F0F;
`ifdef MILANO_FETCH_BYPASS_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 2;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] boot_addr, branch_addr;
  logic        fetch_enable, branch, gnt, ready;
  logic        instr_req_o, id_valid_o, busy_o;
  logic [31:0] instr_addr_o, id_instr_o, id_pc_o;
  logic        rvalid;
  logic [31:0] rdata;

  always #5 clk = ~clk;

  milano_fetch_unit #(.ADDR_W(32), .DEPTH(4)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .boot_addr_i    (boot_addr),
    .fetch_enable_i (fetch_enable),
    .branch_i       (branch),
    .branch_addr_i  (branch_addr),
    .instr_req_o    (instr_req_o),
    .instr_addr_o   (instr_addr_o),
    .instr_gnt_i    (gnt),
    .instr_rvalid_i (rvalid),
    .instr_rdata_i  (rdata),
    .id_valid_o     (id_valid_o),
    .id_ready_i     (ready),
    .id_instr_o     (id_instr_o),
    .id_pc_o        (id_pc_o),
    .busy_o         (busy_o)
  );

  // SRAM model: grant sampled mid-cycle, response in the following cycle.
  logic [31:0] sram_q[$];
  logic        acc_v;
  logic [31:0] acc_a;
  logic        rvalid_en;
  int          grant_cnt;

  always @(negedge clk) begin
    acc_v <= instr_req_o & gnt;
    acc_a <= instr_addr_o;
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sram_q.delete();
      rvalid    <= 1'b0;
      rdata     <= '0;
      grant_cnt <= 0;
    end else begin
      if (acc_v) begin
        sram_q.push_back(acc_a);
        grant_cnt <= grant_cnt + 1;
      end
      if (rvalid_en && sram_q.size() > 0) begin
        rvalid <= 1'b1;
        rdata  <= sram_q.pop_front() ^ RD_XOR;
      end else begin
        rvalid <= 1'b0;
      end
    end
  end

  // ID-side handshake monitor.
  int          cyc = 0;
  logic [31:0] hs_pc[$], hs_instr[$];
  int          hs_cyc[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n && id_valid_o && ready) begin
      hs_pc.push_back(id_pc_o);
      hs_instr.push_back(id_instr_o);
      hs_cyc.push_back(cyc);
    end
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [31:0] boot);
    rst_n        = 1'b0;
    boot_addr    = boot;
    fetch_enable = 1'b0;
    branch       = 1'b0;
    branch_addr  = '0;
    gnt          = 1'b1;
    ready        = 1'b1;
    rvalid_en    = 1'b1;
    step();
    step();
    hs_pc.delete();
    hs_instr.delete();
    hs_cyc.delete();
    rst_n = 1'b1;
    step();
  endtask

  task automatic wait_hs(input int n, input string nm);
    int k = 0;
    while (hs_pc.size() < n && k < 200) begin
      step();
      k++;
    end
    chk(nm, 32'(hs_pc.size() >= n), 32'd1);
  endtask

  task automatic wait_grants(input int n, input string nm);
    int k = 0;
    while (grant_cnt < n && k < 200) begin
      step();
      k++;
    end
    chk(nm, 32'(grant_cnt), 32'(n));
  endtask

  typedef struct {
    logic [31:0] boot;
    logic [31:0] pc[3];
  } vec_t;

  vec_t vecs[4];

  initial begin : main
    int          t_req, t_val;
    logic        have;
    logic [31:0] first;

    vecs[0].boot = 32'h8000_0000;
    vecs[0].pc   = '{32'h8000_0000, 32'h8000_0004, 32'h8000_0008};
    vecs[1].boot = 32'hFFFF_FFF8;
    vecs[1].pc   = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000};
    vecs[2].boot = 32'h0000_1000;
    vecs[2].pc   = '{32'h0000_1000, 32'h0000_1004, 32'h0000_1008};
    vecs[3].boot = 32'hFFFF_FFFC;
    vecs[3].pc   = '{32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};

    // Reset state with a non-zero boot address applied.
    rst_n = 1'b0; boot_addr = 32'hDEAD_0000; fetch_enable = 1'b1;
    branch = 1'b0; branch_addr = '0; gnt = 1'b1; ready = 1'b1; rvalid_en = 1'b1;
    step();
    chk("rst_req",   32'(instr_req_o), 32'd0);
    chk("rst_addr",  instr_addr_o,     32'd0);
    chk("rst_valid", 32'(id_valid_o),  32'd0);
    chk("rst_instr", id_instr_o,       32'd0);
    chk("rst_pc",    id_pc_o,          32'd0);
    chk("rst_busy",  32'(busy_o),      32'd0);

    // Table: boot, stream order, PC wrap, back-to-back delivery, latency.
    for (int v = 0; v < 4; v++) begin
      do_reset(vecs[v].boot);
      fetch_enable = 1'b1;
      t_req = -1;
      t_val = -1;
      for (int k = 0; k < 12; k++) begin
        if (t_req < 0 && instr_req_o && gnt) t_req = k;
        if (t_val < 0 && id_valid_o) t_val = k;
        step();
      end
      chk("latency", 32'(t_val - t_req), 32'(LAT));
      wait_hs(3, "stream_cnt");
      if (hs_pc.size() >= 3) begin
        for (int i = 0; i < 3; i++) begin
          chk("stream_pc",    hs_pc[i],    vecs[v].pc[i]);
          chk("stream_instr", hs_instr[i], vecs[v].pc[i] ^ RD_XOR);
        end
        chk("b2b_1", 32'(hs_cyc[1] - hs_cyc[0]), 32'd1);
        chk("b2b_2", 32'(hs_cyc[2] - hs_cyc[1]), 32'd1);
      end
    end

    // Back-pressure: exactly DEPTH grants, stable head, in-order resume.
    do_reset(32'h8000_0000);
    ready = 1'b0;
    fetch_enable = 1'b1;
    have = 1'b0;
    first = '0;
    for (int k = 0; k < 10; k++) begin
      step();
      if (id_valid_o) begin
        if (!have) begin
          first = id_instr_o;
          have  = 1'b1;
        end else begin
          chk("stall_stable", id_instr_o, first);
        end
      end
    end
    chk("stall_grants", 32'(grant_cnt),   32'd4);
    chk("stall_req",    32'(instr_req_o), 32'd0);
    chk("stall_head",   first,            32'h8000_0000 ^ RD_XOR);
    ready = 1'b1;
    wait_hs(6, "resume_cnt");
    if (hs_pc.size() >= 6)
      for (int i = 0; i < 6; i++)
        chk("resume_pc", hs_pc[i], 32'h8000_0000 + 32'(4 * i));

    // Redirect with two fetches outstanding.
    do_reset(32'h8000_0000);
    rvalid_en = 1'b0;
    fetch_enable = 1'b1;
    wait_grants(2, "br2_grants");
    branch = 1'b1;
    branch_addr = 32'h0000_0100;
    step();
    branch = 1'b0;
    rvalid_en = 1'b1;
    chk("br2_novalid", 32'(id_valid_o), 32'd0);
    wait_hs(2, "br2_cnt");
    if (hs_pc.size() >= 2) begin
      chk("br2_pc0",    hs_pc[0],    32'h0000_0100);
      chk("br2_pc1",    hs_pc[1],    32'h0000_0104);
      chk("br2_instr0", hs_instr[0], 32'h0000_0100 ^ RD_XOR);
    end

    // Redirect in the same cycle as a response, FIFO non-empty.
    do_reset(32'h0000_0200);
    ready = 1'b0;
    fetch_enable = 1'b1;
    for (int k = 0; k < 20 && !id_valid_o; k++) step();
    chk("br4_fill", 32'(id_valid_o), 32'd1);
    rvalid_en = 1'b0;
    for (int k = 0; k < 4; k++) step();
    rvalid_en = 1'b1;
    step();
    chk("br4_rvalid", 32'(rvalid), 32'd1);
    branch = 1'b1;
    branch_addr = 32'h0000_0300;
    step();
    branch = 1'b0;
    chk("br4_flush", 32'(id_valid_o), 32'd0);
    ready = 1'b1;
    wait_hs(2, "br4_cnt");
    if (hs_pc.size() >= 2) begin
      chk("br4_pc0", hs_pc[0], 32'h0000_0300);
      chk("br4_pc1", hs_pc[1], 32'h0000_0304);
    end

    // Disable with three outstanding: DRAIN, busy until last response.
    do_reset(32'h0000_0400);
    rvalid_en = 1'b0;
    fetch_enable = 1'b1;
    wait_grants(3, "dr_grants");
    fetch_enable = 1'b0;
    step();
    chk("dr_busy",  32'(busy_o),      32'd1);
    chk("dr_noreq", 32'(instr_req_o), 32'd0);
    rvalid_en = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("dr_rvalid",   32'(rvalid), 32'd1);
      chk("dr_busy_rsp", 32'(busy_o), 32'd1);
    end
    step();
    chk("dr_idle",  32'(busy_o),      32'd0);
    chk("dr_req0",  32'(instr_req_o), 32'd0);
    wait_hs(3, "dr_cnt");
    if (hs_pc.size() >= 3)
      for (int i = 0; i < 3; i++)
        chk("dr_pc", hs_pc[i], 32'h0000_0400 + 32'(4 * i));
    fetch_enable = 1'b1;
    step();
    chk("dr_resume_req",  32'(instr_req_o), 32'd1);
    chk("dr_resume_addr", instr_addr_o,     32'h0000_040C);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
